// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and defaults.
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START_BIT,
    RX_DATA,
    RX_PARITY_BIT,
    RX_STOP_BIT,
    RX_STOP_BIT_2
  } uart_rx_state_e;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop rx synchronizer; with UART_RX_MAJORITY_EN defined,
// the sampled bit is a 2-of-3 vote over the current and two previous ticks.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
`ifdef UART_RX_MAJORITY_EN
  input  logic i_tick,
`endif
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_bit
);
  logic [1:0] r_sync;
  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], i_rx};
  end
  assign o_rx_s = r_sync[1];
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;
  always_ff @(posedge clk) begin
    if (reset) r_hist <= 2'b11;
    else if (i_tick) r_hist <= {r_hist[0], r_sync[1]};
  end
  assign o_bit = maj3(r_hist[1], r_hist[0], r_sync[1]);
`else
  assign o_bit = r_sync[1];
`endif
endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: oversampled UART receiver feeding an RX queue.
// Optional UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_clk_en,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 double_stop_bit,
  input  logic                 rx_queue_full,
  output logic                 rx_queue_we,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // With majority voting the decision lands one tick after the nominal point;
  // restarting the counter at MAJ keeps every later window centred.
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 - 1 + MAJ);
  localparam logic [CW-1:0] BIT_PT   = CW'((OVERSAMPLE - 1 + MAJ) % OVERSAMPLE);
  localparam logic [CW-1:0] REARM    = CW'(MAJ);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_rx_state_e       r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bits;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_par_en, r_dbl, r_perr, r_ferr;
  logic                 w_rx_s, w_bit, w_at_start, w_at_bit, w_done, w_ferr, w_perr;

  uart_rx_sampler u_sampler (
    .clk    (clk),
    .reset  (reset),
`ifdef UART_RX_MAJORITY_EN
    .i_tick (rx_clk_en),
`endif
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_bit  (w_bit)
  );

  assign w_at_start = r_cnt == START_PT;
  assign w_at_bit   = r_cnt == BIT_PT;
  assign w_done     = rx_clk_en && w_at_bit &&
                      ((r_state == RX_STOP_BIT && !r_dbl) || r_state == RX_STOP_BIT_2);
  assign w_ferr     = r_ferr | ~w_bit;
  assign w_perr     = r_perr & ~w_ferr;

  always_comb begin
    w_next      = r_state;
    frame_err   = w_done & w_ferr;
    parity_err  = w_done & w_perr;
    overrun_err = w_done & ~w_ferr & ~r_perr & rx_queue_full;
    rx_queue_we = w_done & ~w_ferr & ~r_perr & ~rx_queue_full;
    if (rx_clk_en) begin
      case (r_state)
        RX_IDLE:       w_next = w_rx_s ? RX_IDLE : RX_START_BIT;
        RX_START_BIT:  if (w_at_start) w_next = w_bit ? RX_IDLE : RX_DATA;
        RX_DATA:       if (w_at_bit && r_bits == LAST_BIT) w_next = r_par_en ? RX_PARITY_BIT : RX_STOP_BIT;
        RX_PARITY_BIT: if (w_at_bit) w_next = RX_STOP_BIT;
        RX_STOP_BIT:   if (w_at_bit) w_next = r_dbl ? RX_STOP_BIT_2 : RX_IDLE;
        RX_STOP_BIT_2: if (w_at_bit) w_next = RX_IDLE;
        default:       w_next = RX_IDLE;
      endcase
    end
  end

  assign rx_data = rx_queue_we ? r_shift : r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RX_IDLE;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_par_en <= 1'b0;
      r_dbl    <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (rx_queue_we) r_data <= r_shift;
      if (rx_clk_en) begin
        r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        case (r_state)
          RX_IDLE: begin
            r_cnt  <= '0;
            r_bits <= '0;
            if (!w_rx_s) begin
              r_par_en <= parity_en;
              r_dbl    <= double_stop_bit;
              r_perr   <= 1'b0;
              r_ferr   <= 1'b0;
            end
          end
          RX_START_BIT: if (w_at_start) r_cnt <= REARM;
          RX_DATA: if (w_at_bit) begin
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bits  <= r_bits + 1'b1;
          end
          RX_PARITY_BIT: if (w_at_bit) r_perr <= ^{r_shift, w_bit};
          RX_STOP_BIT:   if (w_at_bit) r_ferr <= ~w_bit;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed frames with a queue-based scoreboard.
module tb_uart_rx_controller;
  logic       clk = 0, reset = 1, rx_clk_en = 0, rx = 1;
  logic       parity_en = 0, double_stop_bit = 0, rx_queue_full = 0;
  logic       rx_queue_we, frame_err, parity_err, overrun_err;
  logic [7:0] rx_data;
  int         errors = 0, checks = 0;

  typedef struct packed {logic [1:0] kind; logic [7:0] data;} exp_t;
  localparam logic [1:0] K_WE = 0, K_FE = 1, K_PE = 2, K_OE = 3;
  exp_t q[$];

  uart_rx_controller dut (
    .clk(clk), .reset(reset), .rx_clk_en(rx_clk_en), .rx(rx),
    .parity_en(parity_en), .double_stop_bit(double_stop_bit),
    .rx_queue_full(rx_queue_full), .rx_queue_we(rx_queue_we), .rx_data(rx_data),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    int tc = 0;
    forever begin
      @(negedge clk);
      tc = (tc + 1) % 4;
      rx_clk_en = (tc == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_queue_we | frame_err | parity_err | overrun_err) begin
        chk("onehot_pulse", $countones({rx_queue_we, frame_err, parity_err, overrun_err}), 1);
        if (q.size() == 0) chk("unexpected_pulse", {rx_queue_we, frame_err, parity_err, overrun_err}, 0);
        else begin
          e = q.pop_front();
          chk("pulse_kind", rx_queue_we ? K_WE : frame_err ? K_FE : parity_err ? K_PE : K_OE, e.kind);
          if (rx_queue_we) chk("rx_data_on_we", rx_data, e.data);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic dbl, input logic s1, input logic s2);
    parity_en = pe;
    double_stop_bit = dbl;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pbit);
    send_bit(s1);
    if (dbl) send_bit(s2);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_outputs", {rx_queue_we, frame_err, parity_err, overrun_err}, 0);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("idle_outputs", {rx_queue_we, frame_err, parity_err, overrun_err}, 0);

    q.push_back({K_WE, 8'h55});
    send_frame(8'h55, 0, 0, 0, 1, 1);
    chk("hold_after_55", rx_data, 8'h55);

    q.push_back({K_PE, 8'h00});
    send_frame(8'hA3, 1, 1, 0, 1, 1);
    chk("hold_after_parity_err", rx_data, 8'h55);

    q.push_back({K_FE, 8'h00});
    send_frame(8'h0F, 0, 0, 0, 0, 1);
    chk("hold_after_frame_err", rx_data, 8'h55);

    rx = 0;
    repeat (16) @(negedge clk);
    rx = 1;
    repeat (3 * 64) @(negedge clk);
    chk("glitch_no_change", rx_data, 8'h55);

    rx_queue_full = 1;
    q.push_back({K_OE, 8'h00});
    send_frame(8'h3C, 0, 0, 0, 1, 1);
    chk("hold_after_overrun", rx_data, 8'h55);
    rx_queue_full = 0;
    q.push_back({K_WE, 8'hC3});
    send_frame(8'hC3, 0, 0, 0, 1, 1);
    chk("hold_after_C3", rx_data, 8'hC3);

    q.push_back({K_WE, 8'h96});
    send_frame(8'h96, 1, 0, 1, 1, 1);
    q.push_back({K_FE, 8'h00});
    send_frame(8'h5A, 0, 0, 1, 1, 0);
    chk("hold_after_stop2_err", rx_data, 8'h96);

    parity_en = 0;
    double_stop_bit = 0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1;
    rx = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (4 * 64) @(negedge clk);
    chk("rx_data_after_mid_reset", rx_data, 8'h00);
    q.push_back({K_WE, 8'h81});
    send_frame(8'h81, 0, 0, 0, 1, 1);
    chk("hold_after_81", rx_data, 8'h81);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_controller.md
UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16, rx_clk_en ticks per bit period.
REQ-003 clk  input  1  system clock; the block has one clock and all logic uses its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_clk_en  input  1  single-cycle oversample tick at OVERSAMPLE x baud rate.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 parity_en  input  1  the frame carries an even parity bit after the data bits.
REQ-008 double_stop_bit  input  1  the frame carries two stop bits.
REQ-009 rx_queue_full  input  1  the downstream RX queue cannot accept a write.
REQ-010 rx_queue_we  output  1  single-clk-cycle write strobe to the RX queue.
REQ-011 rx_data  output  DATA_BITS  received byte; valid while rx_queue_we=1 and held until the next write.
REQ-012 frame_err  output  1  single-cycle pulse: a stop bit was sampled low.
REQ-013 parity_err  output  1  single-cycle pulse: parity mismatch.
REQ-014 overrun_err  output  1  single-cycle pulse: a good frame was dropped because the queue was full.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-016 States SHALL be RX_IDLE, RX_START_BIT, RX_DATA, RX_PARITY_BIT, RX_STOP_BIT, RX_STOP_BIT_2; state, counters and shift register SHALL advance only in cycles with rx_clk_en=1.
REQ-017 RX_IDLE: when rx_s=0 on a tick, the FSM SHALL go to RX_START_BIT and clear the tick counter to 0.
REQ-018 The tick counter SHALL count 0..OVERSAMPLE-1 and wrap; the sample point SHALL be the tick where the counter equals OVERSAMPLE/2-1 (7) in RX_START_BIT and OVERSAMPLE-1 (15) in every later state.
REQ-019 RX_START_BIT: sample=1 -> false start, return to RX_IDLE with no output; sample=0 -> RX_DATA with the counter and bit counter cleared.
REQ-020 RX_DATA: each sample SHALL shift in LSB first; after DATA_BITS samples -> RX_PARITY_BIT if parity_en, else RX_STOP_BIT.
REQ-021 RX_PARITY_BIT: a parity error SHALL be latched when XOR(data bits, parity sample) != 0; then -> RX_STOP_BIT.
REQ-022 RX_STOP_BIT: sample=0 latches a framing error; -> RX_STOP_BIT_2 if double_stop_bit, else completion.
REQ-023 RX_STOP_BIT_2: sample=0 latches a framing error; then completion.
REQ-024 Completion (same clk cycle as the final stop sample, then -> RX_IDLE): framing error -> frame_err=1; else parity error -> parity_err=1; else rx_queue_full -> overrun_err=1; else rx_queue_we=1 with rx_data updated.
REQ-025 Errored or overrun frames SHALL NOT be written, and rx_data SHALL keep its previous value.
REQ-026 At most one of rx_queue_we, frame_err, parity_err or overrun_err SHALL be high in any cycle, for exactly one clk cycle.
REQ-027 parity_en and double_stop_bit SHALL be sampled on the RX_IDLE->RX_START_BIT transition and held for the rest of the frame.
REQ-028 If rx_s is low on return to RX_IDLE (break, or back-to-back frame), a new frame SHALL start on the next tick.

Reset
REQ-029 reset SHALL force state RX_IDLE, clear all counters, rx_data=0 and all outputs to 0, and preset the synchronizer flops to 1.
REQ-030 Reset mid-frame SHALL abort the frame with no write and no error pulse.

Configuration
REQ-031 Macro UART_RX_MAJORITY_EN: when defined, each sample SHALL be the 2-of-3 majority of rx_s at counter values S-1, S and S+1, where S is the nominal sample point, and the decision SHALL be taken at S+1; when undefined, a single sample SHALL be taken at S.

Structure
REQ-032 The state enum type and the OVERSAMPLE default SHALL live in the shared package uart_pkg.
REQ-033 The synchronizer and majority filter SHALL be the sub-module uart_rx_sampler.

Verification
REQ-034 Frame 0x55 (8N1, 16 ticks/bit) -> one rx_queue_we pulse with rx_data=0x55, no error pulses.
REQ-035 0xA3 with parity_en=1 and a parity bit of 1 -> parity_err pulse, no write, rx_data unchanged.
REQ-036 0x0F with the stop bit driven low -> frame_err pulse, no write.
REQ-037 Low glitch of 4 ticks on an idle line -> false start, FSM returns to RX_IDLE, no outputs.
REQ-038 rx_queue_full=1 during a good frame 0x3C -> overrun_err pulse, no write; the next frame 0xC3 with full=0 -> written.
REQ-039 reset asserted mid-data of 0x7E -> no pulse; a following frame 0x81 -> received correctly.
